// File: rtl/lt24_frame_streamer.sv
// Purpose: raster scanner that requests pixels from a fixed-latency renderer and streams them to the LT24 controller.
// Latency: first pixelWrite RENDER_LATENCY+1 cycles after the first req_valid; then 1 pixel/cycle with pixelReady high.
// Backpressure: requests are credit-limited by FIFO occupancy plus in-flight renders, so pixelReady=0 never drops a colour.
//
// Ports:
//   clock, reset               - system clock, synchronous active-high reset
//   enable, win_*              - run control and update window, sampled only when a frame starts
//   req_valid/req_x/req_y      - address stream to the renderer; rgb_in returns RENDER_LATENCY cycles later
//   xAddr/yAddr/pixelData      - FIFO head presented to the display
//   pixelWrite/pixelReady      - display write handshake; pixel is consumed when both are high
//   frame_start/frame_done     - one-cycle frame boundary pulses
//   game_tick/frame_count/busy - frame-synchronous tick, completed-frame counter, scanner activity
module lt24_frame_streamer #(
    parameter int WIDTH          = 240,
    parameter int HEIGHT         = 320,
    parameter int RENDER_LATENCY = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int TICK_FRAMES    = 1,
    parameter int XW             = $clog2(WIDTH),
    parameter int YW             = $clog2(HEIGHT)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [XW-1:0] win_x0,
    input  logic [XW-1:0] win_x1,
    input  logic [YW-1:0] win_y0,
    input  logic [YW-1:0] win_y1,
    input  logic          win_en,
    output logic          req_valid,
    output logic [XW-1:0] req_x,
    output logic [YW-1:0] req_y,
    input  logic [15:0]   rgb_in,
    output logic [XW-1:0] xAddr,
    output logic [YW-1:0] yAddr,
    output logic [15:0]   pixelData,
    output logic          pixelWrite,
    input  logic          pixelReady,
    output logic          frame_start,
    output logic          frame_done,
    output logic          game_tick,
    output logic [15:0]   frame_count,
    output logic          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(FIFO_DEPTH + RENDER_LATENCY + 1);
    localparam int TW = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;

    localparam logic [XW:0]   X_LIM = (XW+1)'(WIDTH);
    localparam logic [YW:0]   Y_LIM = (YW+1)'(HEIGHT);
    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [15:0]   rgb;
    } pix_t;

    state_t state, state_nxt;

    logic [XW-1:0] x_lo, x_hi, cur_x;
    logic [YW-1:0] y_lo, y_hi, cur_y;

    logic [RENDER_LATENCY-1:0] pipe_vld;
    logic [XW-1:0]             pipe_x [RENDER_LATENCY];
    logic [YW-1:0]             pipe_y [RENDER_LATENCY];

    pix_t          fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;
    pix_t          head, push_dat;

    logic [OW-1:0] outstanding;
    logic          push, pop, load, last_req, win_ok;
    logic [TW-1:0] tick_cnt;
    logic          frame_start_q;
    logic [15:0]   frame_cnt_q;

    // A malformed or out-of-range window falls back to the full panel.
    assign win_ok = win_en && (win_x0 <= win_x1) && ({1'b0, win_x1} < X_LIM)
                           && (win_y0 <= win_y1) && ({1'b0, win_y1} < Y_LIM);

    assign push     = pipe_vld[RENDER_LATENCY-1];
    assign push_dat = '{x: pipe_x[RENDER_LATENCY-1], y: pipe_y[RENDER_LATENCY-1], rgb: rgb_in};
    assign head     = fifo_mem[rd_ptr];
    assign pixelWrite = (fifo_cnt != '0);
    assign pop      = pixelWrite && pixelReady;
    assign last_req = (cur_x == x_hi) && (cur_y == y_hi);

    // Head is gated so that a flushed FIFO never shows stale memory contents.
    assign xAddr     = pixelWrite ? head.x   : '0;
    assign yAddr     = pixelWrite ? head.y   : '0;
    assign pixelData = pixelWrite ? head.rgb : '0;

    assign req_x       = cur_x;
    assign req_y       = cur_y;
    assign frame_start = frame_start_q;
    assign frame_count = frame_cnt_q;
    assign busy        = (state != IDLE);
    assign game_tick   = frame_done && (tick_cnt == TW'(TICK_FRAMES - 1));

    // Credits: every request in the render pipe already owns a FIFO slot.
    always_comb begin
        outstanding = OW'(fifo_cnt);
        for (int i = 0; i < RENDER_LATENCY; i++) begin
            outstanding = outstanding + OW'(pipe_vld[i]);
        end
    end

    always_comb begin
        state_nxt  = state;
        req_valid  = 1'b0;
        frame_done = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    load      = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                // A pop this cycle frees the slot the new request will need.
                req_valid = (outstanding < OW'(FIFO_DEPTH)) ||
                            ((outstanding == OW'(FIFO_DEPTH)) && pop);
                if (req_valid && last_req) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Final accept: the only pixel left anywhere leaves the FIFO now.
                if (!reset && pop && (fifo_cnt == CW'(1)) && (pipe_vld == '0)) begin
                    frame_done = 1'b1;
                    if (enable) begin
                        load      = 1'b1;
                        state_nxt = SCAN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_lo          <= '0;
            x_hi          <= '0;
            y_lo          <= '0;
            y_hi          <= '0;
            cur_x         <= '0;
            cur_y         <= '0;
            pipe_vld      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            tick_cnt      <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            frame_start_q <= load;
            if (load) begin
                x_lo  <= win_ok ? win_x0 : '0;
                x_hi  <= win_ok ? win_x1 : X_MAX;
                y_lo  <= win_ok ? win_y0 : '0;
                y_hi  <= win_ok ? win_y1 : Y_MAX;
                cur_x <= win_ok ? win_x0 : '0;
                cur_y <= win_ok ? win_y0 : '0;
            end else if (req_valid && !last_req) begin
                if (cur_x == x_hi) begin
                    cur_x <= x_lo;
                    cur_y <= cur_y + 1'b1;
                end else begin
                    cur_x <= cur_x + 1'b1;
                end
            end

            pipe_vld[0] <= req_valid;
            for (int i = 1; i < RENDER_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (frame_done) begin
                tick_cnt    <= (tick_cnt == TW'(TICK_FRAMES - 1)) ? '0 : tick_cnt + 1'b1;
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    // Datapath only: qualified by pipe_vld / fifo_cnt, so no reset needed.
    always_ff @(posedge clock) begin
        pipe_x[0] <= cur_x;
        pipe_y[0] <= cur_y;
        for (int i = 1; i < RENDER_LATENCY; i++) begin
            pipe_x[i] <= pipe_x[i-1];
            pipe_y[i] <= pipe_y[i-1];
        end
        if (push) begin
            fifo_mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: tb/tb_lt24_frame_streamer.sv
module tb_lt24_frame_streamer;

    localparam int W = 4;
    localparam int H = 3;
    localparam int L = 2;
    localparam int D = 4;
    localparam int T = 3;
    localparam int XW = 2;
    localparam int YW = 2;

    logic          clock = 1'b0;
    logic          reset, enable, win_en, pixelReady;
    logic [XW-1:0] win_x0, win_x1;
    logic [YW-1:0] win_y0, win_y1;
    logic [15:0]   rgb_in;
    logic          req_valid, pixelWrite, frame_start, frame_done, game_tick, busy;
    logic [XW-1:0] req_x, xAddr;
    logic [YW-1:0] req_y, yAddr;
    logic [15:0]   pixelData, frame_count;

    lt24_frame_streamer #(
        .WIDTH(W), .HEIGHT(H), .RENDER_LATENCY(L), .FIFO_DEPTH(D), .TICK_FRAMES(T)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1), .win_en(win_en),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .rgb_in(rgb_in),
        .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
        .pixelWrite(pixelWrite), .pixelReady(pixelReady),
        .frame_start(frame_start), .frame_done(frame_done), .game_tick(game_tick),
        .frame_count(frame_count), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state
    logic [31:0] acc_q[$];
    int          n_fs = 0, n_fd = 0, n_tick = 0;
    logic [7:0]  tick_mask = '0;
    int          stall_err = 0, credit_err = 0, gap_err = 0, fd_err = 0;
    int          out_cnt = 0, cyc = 0, first_req = -1, first_wr = -1;
    logic [31:0] last_fd_pix = '0;

    // Renderer model state
    bit            smp_v;
    logic [XW-1:0] smp_x;
    logic [YW-1:0] smp_y;
    bit            rp_v [L];
    int            rp_x [L];
    int            rp_y [L];
    int            rdy_mode = 0;

    function automatic logic [15:0] rgb_of(input int x, input int y);
        return 16'hA500 ^ 16'((y << 8) | (x * 17));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        acc_q.delete();
        n_fs = 0;
        n_fd = 0;
        n_tick = 0;
        tick_mask = '0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_fd(input int target, input string tag);
        int k = 0;
        while (n_fd < target && k < 3000) begin
            @(negedge clock);
            #1;
            k++;
        end
        chk({tag, "_done_reached"}, n_fd, target);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl_zero"}, 32'({req_valid, pixelWrite, frame_start, frame_done, game_tick, busy,
                                     req_x, req_y, xAddr, yAddr}), 32'd0);
        chk({tag, "_data_zero"}, {pixelData, frame_count}, 32'd0);
    endtask

    task automatic chk_frame(input string tag, input int x0, input int x1, input int y0, input int y1,
                             input int nfr);
        int w = x1 - x0 + 1;
        int n = w * (y1 - y0 + 1);
        chk({tag, "_count"}, acc_q.size(), n * nfr);
        for (int i = 0; i < acc_q.size() && i < n * nfr; i++) begin
            int j, ex, ey;
            j  = i % n;
            ex = x0 + j % w;
            ey = y0 + j / w;
            chk($sformatf("%s_pix%0d", tag, i), acc_q[i], {8'(ex), 8'(ey), rgb_of(ex, ey)});
        end
    endtask

    // Display-side monitor, sampled on the falling edge.
    initial begin : monitor
        logic        acc;
        logic [31:0] head;
        logic        prev_stall;
        logic [31:0] prev_head;
        logic        prev_fd_en;
        prev_stall = 1'b0;
        prev_head  = '0;
        prev_fd_en = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            smp_v = req_valid;
            smp_x = req_x;
            smp_y = req_y;
            acc   = pixelWrite && pixelReady;
            head  = {8'(xAddr), 8'(yAddr), pixelData};
            if (reset) begin
                out_cnt    = 0;
                prev_stall = 1'b0;
                prev_fd_en = 1'b0;
            end else begin
                if (prev_stall && !(pixelWrite && head == prev_head)) stall_err++;
                if (out_cnt > D) credit_err++;
                if (req_valid && out_cnt >= D && !acc) credit_err++;
                if (prev_fd_en && !frame_start) gap_err++;
                if (frame_done && !acc) fd_err++;
                if (req_valid && first_req < 0) first_req = cyc;
                if (pixelWrite && first_wr < 0) first_wr = cyc;
                if (acc) acc_q.push_back(head);
                if (frame_start) n_fs++;
                if (frame_done) begin
                    if (game_tick && n_fd < 8) tick_mask[n_fd] = 1'b1;
                    last_fd_pix = head;
                    n_fd++;
                end
                if (game_tick) n_tick++;
                out_cnt = out_cnt + int'(req_valid) - int'(acc);
                prev_stall = pixelWrite && !pixelReady;
                prev_head  = head;
                prev_fd_en = frame_done && enable;
            end
        end
    end

    // Renderer with exactly L cycles of latency, plus the display ready source.
    initial begin : renderer
        forever begin
            @(posedge clock);
            #1;
            for (int i = L - 1; i > 0; i--) begin
                rp_v[i] = rp_v[i-1];
                rp_x[i] = rp_x[i-1];
                rp_y[i] = rp_y[i-1];
            end
            rp_v[0] = smp_v;
            rp_x[0] = int'(smp_x);
            rp_y[0] = int'(smp_y);
            rgb_in  = rp_v[L-1] ? rgb_of(rp_x[L-1], rp_y[L-1]) : 16'hDEAD;
            pixelReady = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
        end
    end

    initial begin : stimulus
        int k;
        reset = 1'b1; enable = 1'b1; win_en = 1'b0;
        win_x0 = '0; win_x1 = '0; win_y0 = '0; win_y1 = '0;
        pixelReady = 1'b1; rgb_in = '0;

        // Reset state
        @(negedge clock);
        #1;
        chk_all_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Full frame, no back-pressure
        wait_fd(1, "a");
        chk_frame("a", 0, W - 1, 0, H - 1, 1);
        chk("a_fill_latency", first_wr - first_req, 3);
        chk("a_done_on_last", last_fd_pix, {8'd3, 8'd2, rgb_of(3, 2)});
        chk("a_fcount_at_done", frame_count, 0);
        clear_mon();
        @(negedge clock);
        #1;
        chk("a_fcount", frame_count, 1);
        chk("a_restart_no_gap", frame_start, 1);
        chk("a_busy", busy, 1);

        // Second frame with 30% ready duty; enable dropped mid-frame
        @(posedge clock);
        #1;
        enable = 1'b0;
        rdy_mode = 1;
        wait_fd(1, "b");
        chk_frame("b", 0, W - 1, 0, H - 1, 1);
        chk("b_head_stable", stall_err, 0);
        chk("b_credit", credit_err, 0);
        @(negedge clock);
        #1;
        chk("b_idle_busy", busy, 0);
        chk("b_fcount", frame_count, 2);

        // Valid window; window inputs scrambled once the frame is running
        @(posedge clock);
        #1;
        rdy_mode = 0;
        win_en = 1'b1; win_x0 = 2'd1; win_x1 = 2'd2; win_y0 = 2'd1; win_y1 = 2'd1;
        enable = 1'b1;
        clear_mon();
        @(posedge clock);
        #1;
        enable = 1'b0;
        win_en = 1'b0; win_x0 = 2'd0; win_x1 = 2'd3;
        wait_fd(1, "c");
        tick_n(6);
        chk_frame("c", 1, 2, 1, 1, 1);
        chk("c_starts", n_fs, 1);
        chk("c_dones", n_fd, 1);
        chk("c_tick_frame3", n_tick, 1);

        // Inverted window falls back to full frame
        win_en = 1'b1; win_x0 = 2'd3; win_x1 = 2'd1; win_y0 = 2'd0; win_y1 = 2'd2;
        enable = 1'b1;
        clear_mon();
        @(posedge clock);
        #1;
        enable = 1'b0;
        wait_fd(1, "d");
        tick_n(4);
        chk_frame("d", 0, W - 1, 0, H - 1, 1);
        chk("d_starts", n_fs, 1);
        chk("d_no_tick", n_tick, 0);

        // Reset after five accepts
        win_en = 1'b0;
        enable = 1'b1;
        clear_mon();
        k = 0;
        while (acc_q.size() < 5 && k < 200) begin
            @(negedge clock);
            #1;
            k++;
        end
        chk("e_five_accepts", acc_q.size(), 5);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk_all_zero("e");
        chk("e_no_done", n_fd, 0);
        clear_mon();
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        #1;
        chk("e_fcount_zero", frame_count, 0);

        // Seven back-to-back frames; enable dropped during the seventh
        wait_fd(6, "f6");
        tick_n(3);
        enable = 1'b0;
        wait_fd(7, "f7");
        @(negedge clock);
        #1;
        chk("f_busy_after", busy, 0);
        chk("f_fcount", frame_count, 7);
        chk("f_tick_frames", tick_mask, 8'h24);
        chk("f_tick_count", n_tick, 2);
        chk("f_starts", n_fs, 7);
        chk_frame("f", 0, W - 1, 0, H - 1, 7);
        chk("g_no_gap", gap_err, 0);
        chk("g_done_with_accept", fd_err, 0);
        chk("g_head_stable", stall_err, 0);
        chk("g_credit", credit_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
